// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared types, HD44780 command constants and helper functions
//            for the character-LCD write sequencer.
//            Optional power-up initialisation is enabled by LCD_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Sequencer states; the power-up/init states exist only with LCD_INIT_EN.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
`ifdef LCD_INIT_EN
    ,
    PWRUP = 3'd5,
    INIT  = 3'd6
`endif
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY     = 8'h06;

  // Number of commands in the internal init sequence.
  localparam int LCD_INIT_LEN = 4;

  // Init sequence: 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_CMD_FUNC_8B2L;
      2'd1:    cmd = LCD_CMD_DISP_ON;
      2'd2:    cmd = LCD_CMD_CLEAR;
      default: cmd = LCD_CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic lcd_is_long_cmd(input logic rs, input logic [6:0] data_hi);
    return !rs && ((data_hi == 7'b000_0000) || (data_hi == 7'b000_0001));
  endfunction

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter load value for a dwell of d cycles minus 'sub', floored at zero.
  function automatic int lcd_dwell(input int d, input int sub);
    return (d > sub) ? (d - sub) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timer
// Purpose  : Loadable down-counter with zero flag; the sequencer loads it on
//            every state entry and advances when it reaches zero.
//            (No LCD_INIT_EN dependency.)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Purpose  : HD44780-style character-LCD write sequencer. Accepts one
//            command/data byte per valid/ready handshake and generates the
//            RS/RW/EN/DATA pin timing with cycle-counted delays.
//            Define LCD_INIT_EN to add the power-up wait and internal
//            init sequence (0x38, 0x0C, 0x01, 0x06) after reset.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC    = 2,
  parameter int T_PW_CYC    = 12,
  parameter int T_H_CYC     = 1,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  input  logic       i_lcd_on,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on
);

  localparam int MAX_DLY = lcd_max(lcd_max(lcd_max(T_AS_CYC, T_PW_CYC), lcd_max(T_H_CYC, T_EXEC_CYC)),
                                   lcd_max(T_CLR_CYC, T_PWRUP_CYC));
  localparam int CW      = $clog2(MAX_DLY) + 1;

  // A state lasting D cycles loads D-1. EXEC loads one less because the
  // accept cycle in IDLE is part of the accept-to-ready window, which then
  // equals T_AS+T_PW+T_H+exec exactly.
  localparam logic [CW-1:0] LD_AS    = CW'(lcd_dwell(T_AS_CYC, 1));
  localparam logic [CW-1:0] LD_PW    = CW'(lcd_dwell(T_PW_CYC, 1));
  localparam logic [CW-1:0] LD_H     = CW'(lcd_dwell(T_H_CYC, 1));
  localparam logic [CW-1:0] LD_EXEC  = CW'(lcd_dwell(T_EXEC_CYC, 2));
  localparam logic [CW-1:0] LD_CLR   = CW'(lcd_dwell(T_CLR_CYC, 2));
`ifdef LCD_INIT_EN
  localparam logic [CW-1:0] LD_PWRUP = CW'(lcd_dwell(T_PWRUP_CYC, 1));
  localparam lcd_state_e    RST_STATE = INIT;
`else
  localparam lcd_state_e    RST_STATE = IDLE;
`endif

  lcd_state_e    state_q, state_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          en_q;
  logic          done_q, done_d;
  logic          on_q;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
`ifdef LCD_INIT_EN
  logic          init_q, init_d;   // current transfer belongs to the init sequence
  logic [2:0]    idx_q, idx_d;     // next init command to issue
  logic          pwr_q, pwr_d;     // power-up wait already started
`endif

  lcd_timer #(
    .W (CW)
  ) u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next-state, pin latch and timer load decisions.
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    data_d   = data_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef LCD_INIT_EN
    init_d   = init_q;
    idx_d    = idx_q;
    pwr_d    = pwr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          rs_d     = i_req_rs;
          data_d   = i_req_data;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = PULSE;
          tmr_load = 1'b1;
          tmr_val  = LD_PW;
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_H;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d  = EXEC;
          tmr_load = 1'b1;
          tmr_val  = lcd_is_long_cmd(rs_q, data_q[7:1]) ? LD_CLR : LD_EXEC;
        end
      end
      EXEC: begin
        if (tmr_zero) begin
`ifdef LCD_INIT_EN
          if (init_q) begin
            if (idx_q == 3'(LCD_INIT_LEN)) begin
              state_d = IDLE;
              init_d  = 1'b0;
            end else begin
              state_d = INIT;
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef LCD_INIT_EN
      PWRUP: begin
        if (tmr_zero) begin
          state_d = INIT;
        end
      end
      INIT: begin
        if (!pwr_q) begin
          pwr_d    = 1'b1;
          state_d  = PWRUP;
          tmr_load = 1'b1;
          tmr_val  = LD_PWRUP;
        end else begin
          rs_d     = 1'b0;
          data_d   = lcd_init_cmd(idx_q[1:0]);
          idx_d    = idx_q + 3'd1;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_AS;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and pin registers; EN is registered from the next state so the
  // strobe comes straight off a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RST_STATE;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCD_INIT_EN
      init_q  <= 1'b1;
      idx_q   <= 3'd0;
      pwr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= (state_d == PULSE);
      done_q  <= done_d;
`ifdef LCD_INIT_EN
      init_q  <= init_d;
      idx_q   <= idx_d;
      pwr_q   <= pwr_d;
`endif
    end
  end

  // Backlight/power enable is a plain one-cycle-delayed copy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      on_q <= 1'b0;
    end else begin
      on_q <= i_lcd_on;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = ~o_req_ready;
  assign o_done      = done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_en    = en_q;
  assign o_lcd_on    = on_q;

endmodule
`default_nettype wire
